// File: rtl/pc_sequencer_if.sv
// Decoder/sequencer bus for pc_sequencer: control strobes in, program counter
// and status out. The master side is the decoder, the slave side is the sequencer.
interface pc_sequencer_if #(
  parameter int unsigned D = 12
);
  logic         start;
  logic [D-1:0] start_addr;
  logic         stall;
  logic         op_rel;
  logic         op_abs;
  logic         op_call;
  logic         op_ret;
  logic         op_halt;
  logic         flag;
  logic         invert;
  logic [D-1:0] target;
  logic [D-1:0] prog_ctr;
  logic         busy;
  logic         done;
  logic         ras_err;

  modport master (
    output start, start_addr, stall,
    output op_rel, op_abs, op_call, op_ret, op_halt,
    output flag, invert, target,
    input  prog_ctr, busy, done, ras_err
  );

  modport slave (
    input  start, start_addr, stall,
    input  op_rel, op_abs, op_call, op_ret, op_halt,
    input  flag, invert, target,
    output prog_ctr, busy, done, ras_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-flow controller owning the program counter.
// Sequences IDLE/RUN/HALT, resolves conditional relative/absolute branches,
// honours stall, and with PC_SEQ_RAS_EN defined keeps a call/return stack of
// DEPTH entries with a sticky overflow/underflow error. Without PC_SEQ_RAS_EN
// op_call/op_ret behave as plain sequential steps and ras_err is held at 0.
module pc_sequencer #(
  parameter int unsigned D     = 12,
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         taken;

`ifdef PC_SEQ_RAS_EN
  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [D-1:0]   stack [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic           push;
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  rd_idx;

  assign wr_idx = AW'(sp_q);
  assign rd_idx = AW'(sp_q - SPW'(1));
`endif

  assign taken = bus.flag ^ bus.invert;

  // State, program counter and stack pointer registers; reset wins over all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
`ifdef PC_SEQ_RAS_EN
      sp_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef PC_SEQ_RAS_EN
      sp_q    <= sp_d;
      err_q   <= err_d;
`endif
    end
  end

`ifdef PC_SEQ_RAS_EN
  // Return-address storage; written only on an accepted call.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      stack[wr_idx] <= pc_q + D'(1);
    end
  end
`endif

  // Next state and next program counter, strobes resolved by fixed priority.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_SEQ_RAS_EN
    sp_d    = sp_q;
    err_d   = err_q;
    push    = 1'b0;
`endif
    unique case (state_q)
      IDLE, HALT: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = bus.start_addr;
`ifdef PC_SEQ_RAS_EN
          sp_d    = '0;
          err_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        if (!bus.stall) begin
          if (bus.op_halt) begin
            state_d = HALT;
          end
`ifdef PC_SEQ_RAS_EN
          else if (bus.op_ret) begin
            if (sp_q == '0) begin
              err_d   = 1'b1;
              state_d = HALT;
            end else begin
              pc_d = stack[rd_idx];
              sp_d = sp_q - SPW'(1);
            end
          end else if (bus.op_call) begin
            if (sp_q == SPW'(DEPTH)) begin
              err_d   = 1'b1;
              state_d = HALT;
            end else begin
              push = 1'b1;
              sp_d = sp_q + SPW'(1);
              pc_d = bus.target;
            end
          end
`else
          // Without a stack, call/return still occupy their priority slot
          // and simply advance to the next instruction.
          else if (bus.op_ret || bus.op_call) begin
            pc_d = pc_q + D'(1);
          end
`endif
          else if (bus.op_abs && taken) begin
            pc_d = bus.target;
          end else if (bus.op_rel && taken) begin
            pc_d = pc_q + bus.target;
          end else begin
            pc_d = pc_q + D'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    bus.prog_ctr = pc_q;
    bus.busy     = (state_q == RUN);
    bus.done     = (state_q == HALT);
`ifdef PC_SEQ_RAS_EN
    bus.ras_err  = err_q;
`else
    bus.ras_err  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer (D=12, DEPTH=4). Stack
// sequences are selected by PC_SEQ_RAS_EN to match the build of the DUT.
module tb_pc_sequencer;

  localparam logic [4:0] NOP  = 5'b00000;
  localparam logic [4:0] REL  = 5'b00001;
  localparam logic [4:0] ABS  = 5'b00010;
  localparam logic [4:0] CALL = 5'b00100;
  localparam logic [4:0] RET  = 5'b01000;
  localparam logic [4:0] HLT  = 5'b10000;

  typedef struct {
    logic        rst;
    logic        start;
    logic [11:0] saddr;
    logic        stall;
    logic [4:0]  ops;
    logic        flag;
    logic        inv;
    logic [11:0] tgt;
    logic [11:0] e_pc;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  vec_t vecs[$];

  pc_sequencer_if #(.D(12)) bus ();

  pc_sequencer #(.D(12), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", step_no, name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic start, input logic [11:0] saddr,
                     input logic stall, input logic [4:0] ops, input logic flag,
                     input logic inv, input logic [11:0] tgt, input logic [11:0] e_pc,
                     input logic e_busy, input logic e_done, input logic e_err);
    vec_t v;
    v.rst = rst; v.start = start; v.saddr = saddr; v.stall = stall; v.ops = ops;
    v.flag = flag; v.inv = inv; v.tgt = tgt; v.e_pc = e_pc;
    v.e_busy = e_busy; v.e_done = e_done; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    reset          = v.rst;
    bus.start      = v.start;
    bus.start_addr = v.saddr;
    bus.stall      = v.stall;
    bus.op_halt    = v.ops[4];
    bus.op_ret     = v.ops[3];
    bus.op_call    = v.ops[2];
    bus.op_abs     = v.ops[1];
    bus.op_rel     = v.ops[0];
    bus.flag       = v.flag;
    bus.invert     = v.inv;
    bus.target     = v.tgt;
    @(posedge clk);
    #1;
    check("prog_ctr", bus.prog_ctr, v.e_pc);
    check("busy", 12'(bus.busy), 12'(v.e_busy));
    check("done", 12'(bus.done), 12'(v.e_done));
    check("ras_err", 12'(bus.ras_err), 12'(v.e_err));
    step_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst start saddr stall ops flag inv tgt | pc busy done err
    add(1, 0, 12'h000, 0, NOP,       0, 0, 12'h000, 12'h000, 0, 0, 0);
    add(0, 0, 12'h000, 0, ABS,       1, 0, 12'h123, 12'h000, 0, 0, 0);
    add(0, 0, 12'h000, 1, NOP,       0, 0, 12'h000, 12'h000, 0, 0, 0);
    add(0, 1, 12'h010, 0, NOP,       0, 0, 12'h000, 12'h010, 1, 0, 0);
    add(0, 0, 12'h000, 0, NOP,       0, 0, 12'h000, 12'h011, 1, 0, 0);
    add(0, 0, 12'h000, 0, NOP,       0, 0, 12'h000, 12'h012, 1, 0, 0);
    add(0, 0, 12'h000, 0, ABS,       1, 0, 12'h020, 12'h020, 1, 0, 0);
    add(0, 0, 12'h000, 0, REL,       1, 0, 12'hFFE, 12'h01E, 1, 0, 0);
    add(0, 0, 12'h000, 0, ABS,       1, 0, 12'h020, 12'h020, 1, 0, 0);
    add(0, 0, 12'h000, 0, REL,       1, 1, 12'hFFE, 12'h021, 1, 0, 0);
    add(0, 0, 12'h000, 0, ABS,       0, 1, 12'h100, 12'h100, 1, 0, 0);
    add(0, 0, 12'h000, 0, REL,       0, 0, 12'h004, 12'h101, 1, 0, 0);
    add(0, 0, 12'h000, 0, REL,       0, 1, 12'h004, 12'h105, 1, 0, 0);
    add(0, 0, 12'h000, 0, ABS,       1, 1, 12'h200, 12'h106, 1, 0, 0);
    add(0, 0, 12'h000, 0, ABS | REL, 1, 0, 12'h200, 12'h200, 1, 0, 0);
    add(0, 1, 12'h555, 0, NOP,       0, 0, 12'h000, 12'h201, 1, 0, 0);
    add(0, 0, 12'h000, 0, ABS,       1, 0, 12'hFFF, 12'hFFF, 1, 0, 0);
    add(0, 0, 12'h000, 0, NOP,       0, 0, 12'h000, 12'h000, 1, 0, 0);
    add(0, 0, 12'h000, 1, ABS,       1, 0, 12'h300, 12'h000, 1, 0, 0);
    add(0, 0, 12'h000, 1, HLT,       0, 0, 12'h000, 12'h000, 1, 0, 0);
    add(0, 0, 12'h000, 0, NOP,       0, 0, 12'h000, 12'h001, 1, 0, 0);
    add(0, 0, 12'h000, 0, HLT | ABS, 1, 0, 12'h300, 12'h001, 0, 1, 0);
    add(0, 0, 12'h000, 0, ABS,       1, 0, 12'h300, 12'h001, 0, 1, 0);
    add(0, 1, 12'h000, 0, NOP,       0, 0, 12'h000, 12'h000, 1, 0, 0);
    add(0, 0, 12'h000, 0, ABS,       1, 0, 12'h033, 12'h033, 1, 0, 0);
    add(1, 1, 12'h777, 0, ABS,       1, 0, 12'h444, 12'h000, 0, 0, 0);
    add(0, 0, 12'h000, 0, NOP,       0, 0, 12'h000, 12'h000, 0, 0, 0);
    add(0, 1, 12'hABC, 0, NOP,       0, 0, 12'h000, 12'hABC, 1, 0, 0);

    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();

`ifdef PC_SEQ_RAS_EN
    // call/return, then overflow on the fifth nested call
    add(0, 0, 12'h000, 0, ABS,       1, 0, 12'h005, 12'h005, 1, 0, 0);
    add(0, 0, 12'h000, 0, CALL,      0, 0, 12'h080, 12'h080, 1, 0, 0);
    add(0, 0, 12'h000, 0, RET,       0, 0, 12'h000, 12'h006, 1, 0, 0);
    add(0, 0, 12'h000, 0, CALL,      0, 0, 12'h100, 12'h100, 1, 0, 0);
    add(0, 0, 12'h000, 0, CALL,      0, 0, 12'h200, 12'h200, 1, 0, 0);
    add(0, 0, 12'h000, 0, CALL,      0, 0, 12'h300, 12'h300, 1, 0, 0);
    add(0, 0, 12'h000, 1, RET,       0, 0, 12'h000, 12'h300, 1, 0, 0);
    add(0, 0, 12'h000, 0, CALL,      0, 0, 12'h400, 12'h400, 1, 0, 0);
    add(0, 0, 12'h000, 0, CALL,      0, 0, 12'h500, 12'h400, 0, 1, 1);
    // restart clears the error; nested pop order, then underflow
    add(0, 1, 12'h010, 0, NOP,       0, 0, 12'h000, 12'h010, 1, 0, 0);
    add(0, 0, 12'h000, 0, CALL,      0, 0, 12'h050, 12'h050, 1, 0, 0);
    add(0, 0, 12'h000, 0, CALL | ABS,1, 0, 12'h060, 12'h060, 1, 0, 0);
    add(0, 0, 12'h000, 0, RET | CALL,0, 0, 12'h0F0, 12'h051, 1, 0, 0);
    add(0, 0, 12'h000, 0, RET,       0, 0, 12'h000, 12'h011, 1, 0, 0);
    add(0, 0, 12'h000, 0, RET,       0, 0, 12'h000, 12'h011, 0, 1, 1);
    add(0, 0, 12'h000, 0, NOP,       0, 0, 12'h000, 12'h011, 0, 1, 1);
    add(0, 1, 12'h000, 0, NOP,       0, 0, 12'h000, 12'h000, 1, 0, 0);
`else
    // without the stack, call/return just step to the next address
    add(0, 0, 12'h000, 0, ABS,       1, 0, 12'h005, 12'h005, 1, 0, 0);
    add(0, 0, 12'h000, 0, CALL,      0, 0, 12'h080, 12'h006, 1, 0, 0);
    add(0, 0, 12'h000, 0, RET,       0, 0, 12'h000, 12'h007, 1, 0, 0);
    add(0, 0, 12'h000, 0, RET,       0, 0, 12'h000, 12'h008, 1, 0, 0);
    add(0, 0, 12'h000, 0, HLT | RET, 0, 0, 12'h000, 12'h008, 0, 1, 0);
`endif

    foreach (vecs[i]) apply(vecs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
